// File: rtl/uc_pkg.sv
// Shared decode constants, jump sub-codes, FSM state type and control bundle
// for the uc microcontroller control unit.
package uc_pkg;

  localparam logic [3:0] CLS_LI  = 4'b0000;
  localparam logic [3:0] CLS_JMP = 4'b0001;
  localparam int         ALU_BIT = 3;

  typedef enum logic [1:0] {
    JMP_J    = 2'b00,
    JMP_JZ   = 2'b01,
    JMP_JNZ  = 2'b10,
    JMP_HALT = 2'b11
  } jmp_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic [2:0] op;
  } ctrl_t;

  // Reset keeps the PC incrementing but blocks register writes.
  localparam ctrl_t CTRL_RESET  = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0, op: 3'b000};
  localparam ctrl_t CTRL_HALTED = '{s_inc: 1'b0, s_inm: 1'b0, we3: 1'b0, op: 3'b000};

endpackage

// File: rtl/uc_decode.sv
// Combinational opcode decoder: raw datapath controls plus the event strobes
// the top-level FSM uses to update its flags.
module uc_decode
  import uc_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic       zflag_i,
  output ctrl_t      ctrl_o,
  output logic       is_alu_o,
  output logic       is_halt_o,
  output logic       is_illegal_o
);

  always_comb begin
    ctrl_o       = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0, op: 3'b000};
    is_alu_o     = 1'b0;
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;

    if (opcode_i[ALU_BIT]) begin
      ctrl_o.we3 = 1'b1;
      ctrl_o.op  = opcode_i[2:0];
      is_alu_o   = 1'b1;
    end else if (opcode_i[3:0] == CLS_LI) begin
      ctrl_o.we3   = 1'b1;
      ctrl_o.s_inm = 1'b1;
    end else if (opcode_i[3:0] == CLS_JMP) begin
      // Conditional jumps look only at the registered flag, never the live z.
      case (opcode_i[5:4])
        JMP_JZ:   ctrl_o.s_inc = ~zflag_i;
        JMP_JNZ:  ctrl_o.s_inc = zflag_i;
        JMP_HALT: begin
          ctrl_o.s_inc = 1'b0;
          is_halt_o    = 1'b1;
        end
        default:  ctrl_o.s_inc = 1'b0;
      endcase
    end else begin
      is_illegal_o = 1'b1;
    end
  end

endmodule

// File: rtl/uc.sv
// uc control unit top: decode, RUN/HALTED FSM, zero flag, sticky illegal flag
// and retired-instruction counter.
//
// state     | meaning
// ----------|-------------------------------------------------------------
// ST_RUN    | executing; controls come from the decoder, counter advances
// ST_HALTED | HALT retired; controls forced idle, all flags frozen
module uc
  import uc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             z,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic [2:0]       op,
  output logic             zflag,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_e           state_q, state_d;
  logic             zflag_q, zflag_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  ctrl_t dec_ctrl;
  ctrl_t ctrl;
  logic  is_alu, is_halt, is_illegal;

  uc_decode u_decode (
    .opcode_i     (opcode),
    .zflag_i      (zflag_q),
    .ctrl_o       (dec_ctrl),
    .is_alu_o     (is_alu),
    .is_halt_o    (is_halt),
    .is_illegal_o (is_illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      zflag_q   <= 1'b0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      zflag_q   <= zflag_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    zflag_d   = zflag_q;
    illegal_d = illegal_q;
    instret_d = instret_q;
    ctrl      = dec_ctrl;

    if (state_q == ST_RUN) begin
      instret_d = instret_q + 1'b1;
      if (is_alu)     zflag_d   = z;
      if (is_illegal) illegal_d = 1'b1;
      if (is_halt)    state_d   = ST_HALTED;
    end else begin
      ctrl = CTRL_HALTED;
    end

    // Reset overrides combinationally so no write slips through before the clock.
    if (!reset) ctrl = CTRL_RESET;
  end

  assign s_inc   = ctrl.s_inc;
  assign s_inm   = ctrl.s_inm;
  assign we3     = ctrl.we3;
  assign op      = ctrl.op;
  assign zflag   = zflag_q;
  assign halted  = (state_q == ST_HALTED);
  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule

// File: doc/uc.md
# uc

Control unit for the team's single-cycle, data-memory-less microcontroller datapath. It sits on the other side of the datapath's control interface:
- consumes the 6-bit `opcode` and the ALU zero output `z`;
- drives `s_inc`, `s_inm`, `we3` and `op` in the same cycle.

It adds sequential state the datapath lacks: a registered zero flag for conditional jumps, a terminal HALTED state, a sticky illegal-opcode flag and a retired-instruction counter.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.

- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  opcode field of the current instruction word.
- `z`  in  1  combinational ALU zero output for the current instruction.
- `s_inc`  out  1  PC mux select: 1 = PC+1, 0 = jump target field.
- `s_inm`  out  1  register write-data select: 1 = immediate, 0 = ALU result.
- `we3`  out  1  register-file write enable.
- `op`  out  3  ALU operation.
- `zflag`  out  1  registered zero flag.
- `halted`  out  1  core is in HALTED.
- `illegal`  out  1  sticky; an illegal opcode has executed since reset.
- `instret`  out  CNT_W  retired-instruction count.

## Operation
Decode uses `opcode[3:0]` as the class field and `opcode[5:4]` as a sub-field.

- ALU class (`opcode[3]`=1):
  - `op`=`opcode[2:0]`, `we3`=1, `s_inm`=0, `s_inc`=1.
  - `zflag` loads `z` at the edge.
  - `opcode[5:4]` ignored.
- LI (`opcode[3:0]`=0000): `s_inm`=1, `we3`=1, `s_inc`=1; `opcode[5:4]` ignored.
- Jump class (`opcode[3:0]`=0001), `we3`=0, selected by `opcode[5:4]`:
  - 00 J: `s_inc`=0.
  - 01 JZ: `s_inc`=~`zflag`.
  - 10 JNZ: `s_inc`=`zflag`.
  - 11 HALT: `s_inc`=0, and the FSM enters HALTED at the edge. Programs encode HALT's target as its own address.
- Illegal (`opcode[3:0]` in 0010..0111):
  - Executes as NOP: `we3`=0, `s_inc`=1.
  - `illegal` sets at the edge and stays set until reset.
- Defaults whenever not specified above: `op`=000, `s_inm`=0.
- `zflag` is updated only by ALU-class instructions. Conditional jumps test `zflag`, never the live `z`.

FSM states:
- RUN → HALTED on HALT.
- HALTED → RUN only via reset.
- In HALTED:
  - Outputs are forced to `s_inc`=0, `we3`=0, `s_inm`=0, `op`=000, whatever `opcode` is.
  - `zflag`, `illegal` and `instret` are frozen.

`instret`:
- Increments by 1 at every rising edge in RUN, including the HALT instruction itself and illegal NOPs.
- Wraps modulo 2^CNT_W.

## Timing
- Control outputs are combinational from `opcode`, `zflag` and state, with zero latency, as the single-cycle datapath requires.
- `zflag`, `illegal`, `halted` and `instret` are registered and change one edge after the causing instruction.
- A conditional jump immediately following an ALU instruction sees that ALU instruction's result.
- While `reset`=0 (asynchronous, immediate):
  - State = RUN; `zflag`=0, `illegal`=0, `halted`=0, `instret`=0.
  - `s_inc`=1, `we3`=0, `s_inm`=0, `op`=000. Register writes are suppressed during reset regardless of `opcode`.
- Reset asserted mid-HALTED or mid-program: all registered state clears immediately and RUN resumes at the first edge after release.

## Structure
- Package `uc_pkg` holds:
  - class constants: `CLS_LI`=4'b0000, `CLS_JMP`=4'b0001, ALU-class bit index 3;
  - jump sub-codes J/JZ/JNZ/HALT;
  - state enum {RUN, HALTED}.
- One natural sub-module: `uc_decode`, purely combinational. Maps `opcode` and `zflag` to the raw control signals and event strobes (is_alu, is_halt, is_illegal).
- The top holds the FSM, flag registers, counter and HALTED override.

## Test plan
- Reset, then opcode=001010 (ALU, op=010) with z=1 → `we3`=1, `op`=010, `s_inm`=0, `s_inc`=1; after edge `zflag`=1, `instret`=1.
- LI (000000), then JZ (010001) with `zflag`=1 → `s_inm`=1, `we3`=1; then `s_inc`=0, `we3`=0. JNZ (100001) in the same state → `s_inc`=1.
- ALU with z=0, then LI with z=1, then JZ → `zflag` stays 0 across LI; JZ not taken (`s_inc`=1).
- Illegal 000101 → `we3`=0, `s_inc`=1; after edge `illegal`=1 and stays 1 across 10 further legal instructions.
- HALT (110001) → `s_inc`=0; after edge `halted`=1. Then apply ALU opcode 001000 → `we3`=0, `s_inc`=0, `instret` frozen. Pulse `reset`=0 mid-cycle → outputs clear immediately.
- CNT_W=4, 17 consecutive LIs → `instret` wraps 15→0 and reads 1.
